// File: rtl/ysyx_23060171_pkg.sv
// Shared encodings for the branch resolution unit: jump codes, PC sources,
// FSM states and 2-bit predictor counter values.
package ysyx_23060171_pkg;

   localparam logic [3:0] JMP_BEQ   = 4'b0000;
   localparam logic [3:0] JMP_BNE   = 4'b0001;
   localparam logic [3:0] JMP_BLT   = 4'b0100;
   localparam logic [3:0] JMP_BGE   = 4'b0101;
   localparam logic [3:0] JMP_BLTU  = 4'b0110;
   localparam logic [3:0] JMP_BGEU  = 4'b0111;
   localparam logic [3:0] JMP_JAL   = 4'b1000;
   localparam logic [3:0] JMP_JALR  = 4'b1001;
   localparam logic [3:0] JMP_MRET  = 4'b1010;
   localparam logic [3:0] JMP_NJUMP = 4'b1111;

   typedef enum logic [2:0] {
      PC_PLUS_4   = 3'b000,
      PC_PLUS_IMM = 3'b001,
      PC_PLUS_RS2 = 3'b010,
      PC_MTVEC    = 3'b011,
      PC_MEPC     = 3'b100
   } pcsrc_e;

   typedef enum logic [1:0] {
      ST_INIT  = 2'b00,
      ST_IDLE  = 2'b01,
      ST_REDIR = 2'b10
   } state_e;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
      end
      return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
   endfunction

   function automatic logic is_cond(input logic [3:0] jump);
      return jump inside {JMP_BEQ, JMP_BNE, JMP_BLT, JMP_BGE, JMP_BLTU, JMP_BGEU};
   endfunction

endpackage

// File: rtl/ysyx_23060171_pht.sv
// Pattern history table of 2-bit saturating counters with an init sweep,
// one combinational read port and one saturating update port.
module ysyx_23060171_pht
   import ysyx_23060171_pkg::*;
#(
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned IW       = $clog2(DEPTH),
   parameter logic [1:0]  CTR_INIT = CTR_WNT
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          init_en_i,
   output logic          init_last_o,
   input  logic [IW-1:0] rd_idx_i,
   output logic [1:0]    rd_ctr_o,
   input  logic          upd_en_i,
   input  logic [IW-1:0] upd_idx_i,
   input  logic          upd_taken_i
);

   logic [1:0]    ctr_q [DEPTH];
   logic [IW-1:0] init_idx_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         init_idx_q <= '0;
      end else if (init_en_i) begin
         init_idx_q <= init_idx_q + IW'(1);
      end
   end

   // The array itself is not reset; the init sweep rewrites every entry.
   always_ff @(posedge clock) begin
      if (init_en_i) begin
         ctr_q[init_idx_q] <= CTR_INIT;
      end else if (upd_en_i) begin
         ctr_q[upd_idx_i] <= ctr_update(ctr_q[upd_idx_i], upd_taken_i);
      end
   end

   assign init_last_o = init_en_i && (init_idx_q == IW'(DEPTH - 1));
   assign rd_ctr_o    = ctr_q[rd_idx_i];

endmodule

// File: rtl/ysyx_23060171_bru.sv
// Branch resolution unit: resolves next PC, trains the PHT and issues a
// held redirect when the fetched PC disagrees with the resolved target.
//
// state    | meaning
// ST_INIT  | sweeping CTR_INIT into the PHT, one entry per cycle
// ST_IDLE  | accepting resolve requests
// ST_REDIR | redirect held until IFU accepts it
module ysyx_23060171_bru
   import ysyx_23060171_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned PHT_DEPTH = 64,
   parameter int unsigned IDX_LSB   = 2,
   parameter logic [1:0]  CTR_INIT  = CTR_WNT
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_taken,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [3:0]      ex_jump,
   input  logic            ex_zf,
   input  logic            ex_cmp,
   input  logic            ex_trap,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [XLEN-1:0] ex_jalr_tgt,
   input  logic [XLEN-1:0] ex_mtvec,
   input  logic [XLEN-1:0] ex_mepc,
   input  logic [XLEN-1:0] ex_pred_pc,
   output logic            redir_valid,
   input  logic            redir_ready,
   output logic [XLEN-1:0] redir_pc,
   output logic [2:0]      redir_src,
   output logic [31:0]     mispred_cnt
);

   localparam int unsigned IW = $clog2(PHT_DEPTH);

   state_e            state_q;
   logic              redir_valid_q;
   logic [XLEN-1:0]   redir_pc_q;
   pcsrc_e            redir_src_q;
   logic [31:0]       mispred_cnt_q;

   logic              taken_d;
   logic [XLEN-1:0]   target_d;
   pcsrc_e            src_d;
   logic              accept;
   logic              pht_upd;
   logic              init_last;
   logic [1:0]        if_ctr;
   logic [IW-1:0]     if_idx;
   logic [IW-1:0]     ex_idx;
   logic              unused_if_pc;

   assign if_idx       = if_pc[IDX_LSB +: IW];
   assign ex_idx       = ex_pc[IDX_LSB +: IW];
   assign unused_if_pc = ^if_pc;

   always_comb begin
      taken_d = 1'b0;
      case (ex_jump)
         JMP_BEQ:                      taken_d = ex_zf;
         JMP_BNE:                      taken_d = !ex_zf;
         JMP_BLT, JMP_BLTU:            taken_d = ex_cmp;
         JMP_BGE, JMP_BGEU:            taken_d = !ex_cmp;
         JMP_JAL, JMP_JALR, JMP_MRET:  taken_d = 1'b1;
         JMP_NJUMP:                    taken_d = 1'b0;
         default:                      taken_d = 1'b0;
      endcase
   end

   // A trap wins over whatever the jump code says.
   always_comb begin
      src_d    = PC_PLUS_4;
      target_d = ex_pc + XLEN'(4);
      if (ex_trap) begin
         src_d    = PC_MTVEC;
         target_d = ex_mtvec;
      end else if (ex_jump == JMP_MRET) begin
         src_d    = PC_MEPC;
         target_d = ex_mepc;
      end else if (ex_jump == JMP_JALR) begin
         src_d    = PC_PLUS_RS2;
         target_d = ex_jalr_tgt;
      end else if ((ex_jump == JMP_JAL) || (is_cond(ex_jump) && taken_d)) begin
         src_d    = PC_PLUS_IMM;
         target_d = ex_pc + ex_imm;
      end
   end

   assign accept  = ex_valid && (state_q == ST_IDLE);
   assign pht_upd = accept && is_cond(ex_jump) && !ex_trap;

   ysyx_23060171_pht #(
      .DEPTH    (PHT_DEPTH),
      .IW       (IW),
      .CTR_INIT (CTR_INIT)
   ) u_pht (
      .clock       (clock),
      .reset_n     (reset_n),
      .init_en_i   (state_q == ST_INIT),
      .init_last_o (init_last),
      .rd_idx_i    (if_idx),
      .rd_ctr_o    (if_ctr),
      .upd_en_i    (pht_upd),
      .upd_idx_i   (ex_idx),
      .upd_taken_i (taken_d)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_INIT;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         redir_src_q   <= PC_PLUS_4;
         mispred_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (init_last) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (accept && (target_d != ex_pred_pc)) begin
                  state_q       <= ST_REDIR;
                  redir_valid_q <= 1'b1;
                  redir_pc_q    <= target_d;
                  redir_src_q   <= src_d;
                  mispred_cnt_q <= mispred_cnt_q + 32'd1;
               end
            end
            ST_REDIR: begin
               if (redir_ready) begin
                  state_q       <= ST_IDLE;
                  redir_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_INIT;
            end
         endcase
      end
   end

   assign ex_ready    = (state_q == ST_IDLE);
   assign if_taken    = (state_q != ST_INIT) && (if_ctr >= CTR_WT);
   assign redir_valid = redir_valid_q;
   assign redir_pc    = redir_pc_q;
   assign redir_src   = redir_src_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_ysyx_23060171_bru.sv
// Directed bench for the branch resolution unit with a cycle-level
// behavioural model checked on every falling edge.
module tb_ysyx_23060171_bru;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] if_pc = 32'h0;
   logic        if_taken;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [31:0] ex_pc = 32'h0;
   logic [3:0]  ex_jump = 4'b1111;
   logic        ex_zf = 1'b0;
   logic        ex_cmp = 1'b0;
   logic        ex_trap = 1'b0;
   logic [31:0] ex_imm = 32'h0;
   logic [31:0] ex_jalr_tgt = 32'h0;
   logic [31:0] ex_mtvec = 32'h0;
   logic [31:0] ex_mepc = 32'h0;
   logic [31:0] ex_pred_pc = 32'h0;
   logic        redir_valid;
   logic        redir_ready = 1'b1;
   logic [31:0] redir_pc;
   logic [2:0]  redir_src;
   logic [31:0] mispred_cnt;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   ysyx_23060171_bru dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .if_pc       (if_pc),
      .if_taken    (if_taken),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_pc       (ex_pc),
      .ex_jump     (ex_jump),
      .ex_zf       (ex_zf),
      .ex_cmp      (ex_cmp),
      .ex_trap     (ex_trap),
      .ex_imm      (ex_imm),
      .ex_jalr_tgt (ex_jalr_tgt),
      .ex_mtvec    (ex_mtvec),
      .ex_mepc     (ex_mepc),
      .ex_pred_pc  (ex_pred_pc),
      .redir_valid (redir_valid),
      .redir_ready (redir_ready),
      .redir_pc    (redir_pc),
      .redir_src   (redir_src),
      .mispred_cnt (mispred_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          init_left = 64;
   bit          m_redir = 1'b0;
   logic [31:0] m_rpc = 32'h0;
   logic [2:0]  m_rsrc = 3'b000;
   logic [31:0] m_cnt = 32'h0;
   int          pht_m [64];

   function automatic bit m_is_cond(input logic [3:0] j);
      return (j == 4'd0) || (j == 4'd1) || (j >= 4'd4 && j <= 4'd7);
   endfunction

   function automatic bit m_taken(input logic [3:0] j, input bit zf, input bit cmp);
      if (j == 4'd0) return zf;
      if (j == 4'd1) return !zf;
      if (j == 4'd4 || j == 4'd6) return cmp;
      if (j == 4'd5 || j == 4'd7) return !cmp;
      if (j == 4'd8 || j == 4'd9 || j == 4'd10) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [2:0] m_src();
      if (ex_trap) return 3'd3;
      if (ex_jump == 4'd10) return 3'd4;
      if (ex_jump == 4'd9) return 3'd2;
      if (ex_jump == 4'd8 || (m_is_cond(ex_jump) && m_taken(ex_jump, ex_zf, ex_cmp))) return 3'd1;
      return 3'd0;
   endfunction

   function automatic logic [31:0] m_tgt();
      case (m_src())
         3'd3:    return ex_mtvec;
         3'd4:    return ex_mepc;
         3'd2:    return ex_jalr_tgt;
         3'd1:    return ex_pc + ex_imm;
         default: return ex_pc + 32'd4;
      endcase
   endfunction

   function automatic int m_sat(input int c, input bit t);
      if (t) return (c < 3) ? c + 1 : 3;
      return (c > 0) ? c - 1 : 0;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         init_left <= 64;
         m_redir   <= 1'b0;
         m_rpc     <= 32'h0;
         m_rsrc    <= 3'b000;
         m_cnt     <= 32'h0;
      end else if (init_left > 0) begin
         init_left <= init_left - 1;
         if (init_left == 1) begin
            for (int i = 0; i < 64; i++) pht_m[i] <= 1;
         end
      end else if (m_redir) begin
         if (redir_ready) m_redir <= 1'b0;
      end else if (ex_valid) begin
         if (m_is_cond(ex_jump) && !ex_trap)
            pht_m[ex_pc[7:2]] <= m_sat(pht_m[ex_pc[7:2]], m_taken(ex_jump, ex_zf, ex_cmp));
         if (m_tgt() != ex_pred_pc) begin
            m_redir <= 1'b1;
            m_rpc   <= m_tgt();
            m_rsrc  <= m_src();
            m_cnt   <= m_cnt + 32'd1;
         end
      end
   end

   always @(negedge clock) begin
      if (reset_n) begin
         chk("mdl_ex_ready", {31'd0, ex_ready}, {31'd0, (init_left == 0) && !m_redir});
         chk("mdl_if_taken", {31'd0, if_taken}, {31'd0, (init_left == 0) && (pht_m[if_pc[7:2]] >= 2)});
         chk("mdl_redir_valid", {31'd0, redir_valid}, {31'd0, m_redir});
         chk("mdl_mispred_cnt", mispred_cnt, m_cnt);
         if (m_redir) begin
            chk("mdl_redir_pc", redir_pc, m_rpc);
            chk("mdl_redir_src", {29'd0, redir_src}, {29'd0, m_rsrc});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_ready();
      int n = 0;
      @(negedge clock);
      while (ex_ready !== 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (ex_ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: ex_ready=%b, required 1", ex_ready);
      end
      #1;
   endtask

   task automatic resolve(input logic [3:0] j, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] pred, input logic zf, input logic cmp, input logic trap);
      wait_ready();
      ex_jump = j; ex_pc = pc; ex_imm = imm; ex_pred_pc = pred;
      ex_zf = zf; ex_cmp = cmp; ex_trap = trap; ex_valid = 1'b1;
      @(posedge clock);
      #1 ex_valid = 1'b0;
   endtask

   task automatic probe(input string name, input logic [31:0] pc, input logic exp);
      @(negedge clock);
      #1 if_pc = pc;
      @(negedge clock);
      chk(name, {31'd0, if_taken}, {31'd0, exp});
   endtask

   task automatic init_count();
      int zeros = 0;
      @(negedge clock);
      while (ex_ready === 1'b0 && zeros < 200) begin
         zeros++;
         if (if_taken !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL init_if_taken: got %b, required 0", if_taken);
         end
         @(negedge clock);
      end
      chk("init_cycles", zeros, 32'd64);
   endtask

   typedef struct {
      logic [3:0]  j;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] pred;
      logic        cmp;
      logic        redir;
      logic [31:0] rpc;
   } vec_t;

   vec_t vecs [5] = '{
      '{4'b0100, 32'h80000600, 32'h10,       32'h80000604, 1'b1, 1'b1, 32'h80000610},
      '{4'b0101, 32'h80000610, 32'h10,       32'h80000614, 1'b1, 1'b0, 32'h0},
      '{4'b0110, 32'h80000620, 32'h10,       32'h80000630, 1'b0, 1'b1, 32'h80000624},
      '{4'b0111, 32'h80000630, 32'hFFFFFFF8, 32'h80000628, 1'b0, 1'b0, 32'h0},
      '{4'b1000, 32'h80000700, 32'h100,      32'h80000704, 1'b0, 1'b1, 32'h80000800}
   };

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
      chk("rst_redir_pc", redir_pc, 32'd0);
      chk("rst_redir_src", {29'd0, redir_src}, 32'd0);
      chk("rst_mispred_cnt", mispred_cnt, 32'd0);
      chk("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
      chk("rst_if_taken", {31'd0, if_taken}, 32'd0);
      @(posedge clock);
      #2 reset_n = 1'b1;
      init_count();
      probe("post_init_taken_a", 32'h80000010, 1'b0);
      probe("post_init_taken_b", 32'h0000003C, 1'b0);

      // training toward taken, then saturation
      resolve(4'b0000, 32'h80000010, 32'h8, 32'h80000018, 1'b1, 1'b0, 1'b0);
      @(negedge clock); chk("beq1_no_redir", {31'd0, redir_valid}, 32'd0);
      resolve(4'b0000, 32'h80000010, 32'h8, 32'h80000018, 1'b1, 1'b0, 1'b0);
      @(negedge clock); chk("beq2_no_redir", {31'd0, redir_valid}, 32'd0);
      probe("trained_taken", 32'h80000010, 1'b1);
      resolve(4'b0000, 32'h80000010, 32'h8, 32'h80000018, 1'b1, 1'b0, 1'b0);
      resolve(4'b0000, 32'h80000010, 32'h8, 32'h80000018, 1'b1, 1'b0, 1'b0);
      probe("sat_taken", 32'h80000010, 1'b1);
      resolve(4'b0000, 32'h80000010, 32'h8, 32'h80000014, 1'b0, 1'b0, 1'b0);
      probe("sat_one_down", 32'h80000010, 1'b1);
      resolve(4'b0000, 32'h80000010, 32'h8, 32'h80000014, 1'b0, 1'b0, 1'b0);
      probe("two_down", 32'h80000010, 1'b0);

      // mispredict with a held redirect and a blocked request
      redir_ready = 1'b0;
      resolve(4'b0001, 32'h80000100, 32'hFFFFFFE0, 32'h80000104, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("bne_redir_valid", {31'd0, redir_valid}, 32'd1);
         chk("bne_redir_pc", redir_pc, 32'h800000E0);
         chk("bne_redir_src", {29'd0, redir_src}, 32'd1);
         chk("bne_mispred_cnt", mispred_cnt, 32'd1);
         chk("bne_ex_ready", {31'd0, ex_ready}, 32'd0);
         if (k == 0) begin
            #1;
            ex_jump = 4'b0000; ex_pc = 32'h80000010; ex_zf = 1'b1;
            ex_pred_pc = 32'h0; ex_valid = 1'b1;
         end
      end
      #1;
      ex_valid = 1'b0;
      redir_ready = 1'b1;
      @(negedge clock);
      chk("bne_released", {31'd0, redir_valid}, 32'd0);
      chk("bne_ready_back", {31'd0, ex_ready}, 32'd1);
      chk("blocked_no_count", mispred_cnt, 32'd1);
      probe("blocked_no_train", 32'h80000010, 1'b0);

      // unconditional jumps and trap
      ex_jalr_tgt = 32'h80001000;
      resolve(4'b1001, 32'h80000200, 32'h0, 32'h80000204, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      chk("jalr_pc", redir_pc, 32'h80001000);
      chk("jalr_src", {29'd0, redir_src}, 32'd2);
      chk("jalr_cnt", mispred_cnt, 32'd2);
      ex_mepc = 32'h80000300;
      resolve(4'b1010, 32'h80000204, 32'h0, 32'h80000208, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      chk("mret_pc", redir_pc, 32'h80000300);
      chk("mret_src", {29'd0, redir_src}, 32'd4);
      ex_mtvec = 32'h80000400;
      resolve(4'b0000, 32'h80000010, 32'h8, 32'h80000018, 1'b1, 1'b0, 1'b1);
      @(negedge clock);
      chk("trap_pc", redir_pc, 32'h80000400);
      chk("trap_src", {29'd0, redir_src}, 32'd3);
      chk("trap_cnt", mispred_cnt, 32'd4);
      probe("trap_no_train", 32'h80000010, 1'b0);

      // wrap-around and undefined code
      resolve(4'b1111, 32'hFFFFFFFC, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      chk("wrap_no_redir", {31'd0, redir_valid}, 32'd0);
      resolve(4'b0011, 32'h80000500, 32'h40, 32'h80000540, 1'b1, 1'b1, 1'b0);
      @(negedge clock);
      chk("undef_pc", redir_pc, 32'h80000504);
      chk("undef_src", {29'd0, redir_src}, 32'd0);
      chk("undef_cnt", mispred_cnt, 32'd5);

      for (int v = 0; v < 5; v++) begin
         resolve(vecs[v].j, vecs[v].pc, vecs[v].imm, vecs[v].pred, 1'b0, vecs[v].cmp, 1'b0);
         @(negedge clock);
         chk("vec_redir", {31'd0, redir_valid}, {31'd0, vecs[v].redir});
         if (vecs[v].redir) chk("vec_redir_pc", redir_pc, vecs[v].rpc);
      end
      @(negedge clock);
      chk("vec_cnt", mispred_cnt, 32'd8);

      // reset during a held redirect
      redir_ready = 1'b0;
      resolve(4'b1000, 32'h80000800, 32'h20, 32'h80000804, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      chk("pre_rst_redir", {31'd0, redir_valid}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_redir", {31'd0, redir_valid}, 32'd0);
      chk("async_rst_cnt", mispred_cnt, 32'd0);
      chk("async_rst_pc", redir_pc, 32'd0);
      chk("async_rst_ready", {31'd0, ex_ready}, 32'd0);
      @(posedge clock);
      #2;
      reset_n = 1'b1;
      redir_ready = 1'b1;
      init_count();
      probe("reinit_taken", 32'h80000010, 1'b0);

      #20;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
